// File: rtl/uart_tx_fifo_feeder.sv
// Byte FIFO in front of a UART transmitter: buffers host writes and launches one byte
// per transmitter completion, in write order.
module uart_tx_fifo_feeder #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_Rst,
    input  logic          i_Wr_DV,
    input  logic [7:0]    i_Wr_Byte,
    output logic          o_Full,
    output logic          o_Empty,
    output logic [AW:0]   o_Count,
    output logic          o_Overflow,
    output logic          o_TX_DV,
    output logic [7:0]    o_TX_Byte,
    input  logic          i_TX_Active,
    input  logic          i_TX_Done
);

    typedef enum logic {
        IDLE,
        WAIT_DONE
    } state_t;

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    state_t          state;
    state_t          next_state;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [7:0]      mem [DEPTH];
    logic            wr_accept;
    logic            launch;
    logic [AW:0]     count_next;

    // Full/empty come from the registered flags, so a write racing a pop from a full FIFO
    // is dropped and a freshly written byte cannot launch in the same cycle.
    always_comb begin
        next_state = state;
        launch     = 1'b0;
        wr_accept  = i_Wr_DV && !o_Full;
        case (state)
            IDLE: begin
                if (!o_Empty && !i_TX_Active) begin
                    launch     = 1'b1;
                    next_state = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (i_TX_Done) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase

        count_next = o_Count;
        if (wr_accept && !launch) begin
            count_next = o_Count + (AW + 1)'(1);
        end else if (!wr_accept && launch) begin
            count_next = o_Count - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_Rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= i_Wr_Byte;
        end
    end

    always_ff @(posedge clk) begin
        if (i_Rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_Count    <= '0;
            o_Empty    <= 1'b1;
            o_Full     <= 1'b0;
            o_Overflow <= 1'b0;
            o_TX_DV    <= 1'b0;
            o_TX_Byte  <= 8'h00;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (launch) begin
                rd_ptr    <= rd_ptr + AW'(1);
                o_TX_Byte <= mem[rd_ptr];
            end
            if (i_Wr_DV && o_Full) begin
                o_Overflow <= 1'b1;
            end
            o_TX_DV <= launch;
            o_Count <= count_next;
            o_Full  <= (count_next == FULL_COUNT);
            o_Empty <= (count_next == '0);
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Directed bench for uart_tx_fifo_feeder with a behavioural transmitter (4 clocks per bit,
// 10 bits per frame) and a monitor that logs every launch and done pulse.
module tb_uart_tx_fifo_feeder;

    localparam int DEPTH        = 16;
    localparam int AW           = 4;
    localparam int CLKS_PER_BIT = 4;

    logic        clk = 1'b0;
    logic        i_Rst;
    logic        i_Wr_DV;
    logic [7:0]  i_Wr_Byte;
    logic        o_Full;
    logic        o_Empty;
    logic [AW:0] o_Count;
    logic        o_Overflow;
    logic        o_TX_DV;
    logic [7:0]  o_TX_Byte;
    logic        i_TX_Active;
    logic        i_TX_Done;

    logic        model_en     = 1'b0;
    logic        model_active = 1'b0;
    logic        model_done   = 1'b0;
    logic        force_busy   = 1'b0;
    logic        manual_done  = 1'b0;

    int          compared   = 0;
    int          mismatched = 0;
    int          cyc        = 0;
    logic [7:0]  sent[$];
    int          dv_cyc[$];
    int          done_cyc[$];

    assign i_TX_Active = model_active | force_busy;
    assign i_TX_Done   = model_done | manual_done;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo_feeder #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .i_Rst       (i_Rst),
        .i_Wr_DV     (i_Wr_DV),
        .i_Wr_Byte   (i_Wr_Byte),
        .o_Full      (o_Full),
        .o_Empty     (o_Empty),
        .o_Count     (o_Count),
        .o_Overflow  (o_Overflow),
        .o_TX_DV     (o_TX_DV),
        .o_TX_Byte   (o_TX_Byte),
        .i_TX_Active (i_TX_Active),
        .i_TX_Done   (i_TX_Done)
    );

    always @(negedge clk) begin
        if (o_TX_DV) begin
            sent.push_back(o_TX_Byte);
            dv_cyc.push_back(cyc);
        end
        if (i_TX_Done) begin
            done_cyc.push_back(cyc);
        end
    end

    // Transmitter: accepts a launch only when idle, stays busy for one frame, then pulses done.
    always begin
        @(negedge clk);
        if (model_en && o_TX_DV && !model_active) begin
            @(posedge clk);
            #1 model_active = 1'b1;
            repeat (10 * CLKS_PER_BIT - 1) @(posedge clk);
            #1 model_active = 1'b0;
            model_done = 1'b1;
            @(posedge clk);
            #1 model_done = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        i_Wr_DV   = 1'b1;
        i_Wr_Byte = b;
        tick();
        i_Wr_DV   = 1'b0;
    endtask

    task automatic doReset();
        i_Rst = 1'b1;
        tick();
        tick();
        i_Rst = 1'b0;
        sent.delete();
        dv_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic waitSent(input string tag, input int n, input int limit);
        for (int k = 0; k < limit && sent.size() < n; k++) begin
            tick();
        end
        checkOutput(tag, sent.size(), n);
    endtask

    task automatic pulseDone();
        manual_done = 1'b1;
        tick();
        manual_done = 1'b0;
    endtask

    initial begin
        int pulses;
        logic [7:0] val;

        i_Rst     = 1'b1;
        i_Wr_DV   = 1'b0;
        i_Wr_Byte = 8'h00;
        doReset();

        checkOutput("rst_empty",    o_Empty,    1);
        checkOutput("rst_full",     o_Full,     0);
        checkOutput("rst_count",    o_Count,    0);
        checkOutput("rst_overflow", o_Overflow, 0);
        checkOutput("rst_dv",       o_TX_DV,    0);
        checkOutput("rst_byte",     o_TX_Byte,  8'h00);

        // Single byte: launch two cycles after the write, then silence until done.
        applyStimulus(8'hA5);
        checkOutput("t1_count_n1", o_Count, 1);
        checkOutput("t1_empty_n1", o_Empty, 0);
        checkOutput("t1_dv_n1",    o_TX_DV, 0);
        tick();
        checkOutput("t1_dv_n2",    o_TX_DV, 1);
        checkOutput("t1_byte_n2",  o_TX_Byte, 8'hA5);
        checkOutput("t1_count_n2", o_Count, 0);
        checkOutput("t1_empty_n2", o_Empty, 1);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (o_TX_DV) pulses++;
        end
        checkOutput("t1_no_repeat", pulses, 0);
        checkOutput("t1_byte_held", o_TX_Byte, 8'hA5);
        pulseDone();
        repeat (3) tick();

        // Three bytes through the transmitter model.
        doReset();
        model_en = 1'b1;
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        applyStimulus(8'h03);
        waitSent("t2_wait", 3, 400);
        repeat (50) tick();
        checkOutput("t2_b0", sent[0], 8'h01);
        checkOutput("t2_b1", sent[1], 8'h02);
        checkOutput("t2_b2", sent[2], 8'h03);
        checkOutput("t2_done_cnt", done_cyc.size(), 3);
        checkOutput("t2_gap1", dv_cyc[1] - done_cyc[0], 2);
        checkOutput("t2_gap2", dv_cyc[2] - done_cyc[1], 2);
        model_en = 1'b0;

        // Fill past capacity while busy; a write racing the first pop is dropped too.
        doReset();
        force_busy = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            applyStimulus(8'(8'h10 + i));
        end
        tick();
        checkOutput("t3_full",     o_Full,     1);
        checkOutput("t3_count",    o_Count,    DEPTH);
        checkOutput("t3_overflow", o_Overflow, 1);
        checkOutput("t3_no_tx",    sent.size(), 0);
        force_busy = 1'b0;
        model_en   = 1'b1;
        i_Wr_DV    = 1'b1;
        i_Wr_Byte  = 8'hEE;
        tick();
        i_Wr_DV    = 1'b0;
        checkOutput("t3_race_count", o_Count, DEPTH - 1);
        checkOutput("t3_race_dv",    o_TX_DV, 1);
        waitSent("t3_wait", DEPTH, 1200);
        repeat (100) tick();
        checkOutput("t3_sent_cnt", sent.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            val = (i < sent.size()) ? sent[i] : 8'hFF;
            checkOutput($sformatf("t3_b%0d", i), val, 8'(8'h10 + i));
        end
        checkOutput("t3_ovf_sticky", o_Overflow, 1);
        checkOutput("t3_empty_end",  o_Empty,    1);
        model_en = 1'b0;

        // Stream 3*DEPTH bytes, writing only when there is room, so both pointers wrap.
        doReset();
        model_en = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            for (int k = 0; k < 200 && o_Full; k++) tick();
            applyStimulus(8'(i));
        end
        waitSent("t4_wait", 3 * DEPTH, 3000);
        repeat (50) tick();
        checkOutput("t4_sent_cnt", sent.size(), 3 * DEPTH);
        for (int i = 0; i < 3 * DEPTH; i++) begin
            val = (i < sent.size()) ? sent[i] : 8'hFF;
            checkOutput($sformatf("t4_b%0d", i), val, 8'(i));
        end
        checkOutput("t4_overflow", o_Overflow, 0);
        model_en = 1'b0;

        // Reset while waiting for done with five bytes queued.
        doReset();
        applyStimulus(8'h30);
        repeat (3) tick();
        for (int i = 0; i < 5; i++) applyStimulus(8'(8'h31 + i));
        checkOutput("t5_count_pre", o_Count, 5);
        i_Rst = 1'b1;
        tick();
        i_Rst = 1'b0;
        checkOutput("t5_count", o_Count, 0);
        checkOutput("t5_empty", o_Empty, 1);
        checkOutput("t5_dv",    o_TX_DV, 0);
        checkOutput("t5_byte",  o_TX_Byte, 8'h00);
        tick();
        pulseDone();
        repeat (5) tick();
        checkOutput("t5_no_launch", sent.size(), 1);
        checkOutput("t5_empty_end", o_Empty, 1);

        // Simultaneous write and pop at count 3, then a stray done while idle.
        doReset();
        applyStimulus(8'h61);
        applyStimulus(8'h62);
        applyStimulus(8'h63);
        applyStimulus(8'h64);
        checkOutput("t6_count3", o_Count, 3);
        pulseDone();
        i_Wr_DV   = 1'b1;
        i_Wr_Byte = 8'h65;
        tick();
        i_Wr_DV   = 1'b0;
        checkOutput("t6_count_same", o_Count, 3);
        checkOutput("t6_dv",         o_TX_DV, 1);
        checkOutput("t6_byte",       o_TX_Byte, 8'h62);
        force_busy = 1'b1;
        pulseDone();
        tick();
        pulseDone();
        tick();
        checkOutput("t6_stray_count", o_Count, 3);
        checkOutput("t6_stray_dv",    o_TX_DV, 0);
        checkOutput("t6_stray_sent",  sent.size(), 2);
        force_busy = 1'b0;
        tick();
        checkOutput("t6_next_dv",    o_TX_DV, 1);
        checkOutput("t6_next_byte",  o_TX_Byte, 8'h63);
        checkOutput("t6_next_count", o_Count, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
